vai_tx_rr_arb: RTL and testbench

- Round-robin arbiter that shares one CCI-P Tx request channel (c0 or c1; one instance per channel) among NUM_SUB_AFUS sub-AFUs behind the VAI manager.
- Each requester gets a small skid FIFO and its own almost-full.
- Grants are issued only while the upstream shim's almost-full is low; one request per cycle goes to the manager Tx path through a registered output.
- Per-requester flush supports sub-AFU reset.

---
 rtl/vai_tx_rr_arb.sv | 126 ++++++++++++
 tb/tb_vai_tx_rr_arb.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vai_tx_rr_arb.sv
// vai_tx_rr_arb: round-robin arbiter sharing one CCI-P Tx channel among sub-AFUs, with per-requester skid FIFOs.
// Optional: define VAI_ARB_VMID_TAG_EN to stamp the granted index into the out_data tag field.
`default_nettype none

module vai_tx_rr_arb #(
  parameter int NUM_SUB_AFUS  = 8,
  parameter int DATA_W        = 600,
  parameter int SKID_DEPTH    = 4,
  parameter int ALMFULL_SLACK = 2,
  parameter int TAG_LSB       = 0
) (
  input  logic                             Clk,
  input  logic                             Resetb,
  input  logic [NUM_SUB_AFUS-1:0]          in_valid,
  input  logic [NUM_SUB_AFUS*DATA_W-1:0]   in_data,
  output logic [NUM_SUB_AFUS-1:0]          in_almfull,
  input  logic [NUM_SUB_AFUS-1:0]          flush,
  input  logic                             out_almfull,
  output logic                             out_valid,
  output logic [DATA_W-1:0]                out_data,
  output logic [$clog2(NUM_SUB_AFUS)-1:0]  out_vmid,
  output logic [NUM_SUB_AFUS-1:0]          err_overflow
);

  localparam int IDX_W = $clog2(NUM_SUB_AFUS);
  localparam int PTR_W = $clog2(SKID_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(SKID_DEPTH);
  localparam logic [CNT_W-1:0] ALMFULL_TH = CNT_W'(SKID_DEPTH - ALMFULL_SLACK);

  logic [DATA_W-1:0]       head [NUM_SUB_AFUS];
  logic [NUM_SUB_AFUS-1:0] eligible;
  logic [IDX_W-1:0]        last;
  logic                    grant_vld;
  logic [IDX_W-1:0]        grant_idx;
  logic [DATA_W-1:0]       grant_data;

  for (genvar i = 0; i < NUM_SUB_AFUS; i++) begin : g_fifo
    logic [DATA_W-1:0] mem [SKID_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              push;
    logic              pop;

    assign full = (count == FULL_CNT);
    assign pop  = grant_vld && (grant_idx == IDX_W'(i));
    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
    assign push = in_valid[i] && !flush[i] && (!full || pop);

    assign eligible[i]   = (count != '0) && !flush[i];
    assign in_almfull[i] = (count >= ALMFULL_TH);
    assign head[i]       = mem[rd_ptr];

    always_ff @(posedge Clk or negedge Resetb) begin
      if (!Resetb) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else if (flush[i]) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end

    always_ff @(posedge Clk or negedge Resetb) begin
      if (!Resetb) begin
        err_overflow[i] <= 1'b0;
      end else if (in_valid[i] && !flush[i] && full && !pop) begin
        err_overflow[i] <= 1'b1;
      end
    end

    always_ff @(posedge Clk) begin
      if (push) mem[wr_ptr] <= in_data[i*DATA_W +: DATA_W];
    end
  end

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (!out_almfull) begin
      for (int k = 1; k <= NUM_SUB_AFUS; k++) begin
        if (!grant_vld && eligible[(int'(last) + k) % NUM_SUB_AFUS]) begin
          grant_vld = 1'b1;
          grant_idx = IDX_W'((int'(last) + k) % NUM_SUB_AFUS);
        end
      end
    end
  end

  always_comb begin
    grant_data = head[grant_idx];
`ifdef VAI_ARB_VMID_TAG_EN
    grant_data[TAG_LSB +: IDX_W] = grant_idx;
`else
`endif
  end

  always_ff @(posedge Clk or negedge Resetb) begin
    if (!Resetb) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_vmid  <= '0;
      last      <= IDX_W'(NUM_SUB_AFUS - 1);
    end else begin
      out_valid <= grant_vld;
      if (grant_vld) begin
        out_data <= grant_data;
        out_vmid <= grant_idx;
        last     <= grant_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vai_tx_rr_arb.sv
// tb_vai_tx_rr_arb: randomized and directed checks of vai_tx_rr_arb against a queue-based reference model.
// Honours VAI_ARB_VMID_TAG_EN in the model when the macro is defined.
`default_nettype none

module tb_vai_tx_rr_arb;

  localparam int N     = 8;
  localparam int DW    = 600;
  localparam int DEPTH = 4;
  localparam int SLACK = 2;
  localparam int TLSB  = 0;
  localparam int IW    = $clog2(N);

  logic            Clk = 1'b0;
  logic            Resetb = 1'b0;
  logic [N-1:0]    in_valid = '0;
  logic [N*DW-1:0] in_data = '0;
  logic [N-1:0]    in_almfull;
  logic [N-1:0]    flush = '0;
  logic            out_almfull = 1'b0;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_vmid;
  logic [N-1:0]    err_overflow;

  int checks = 0;
  int errors = 0;

  // Reference model: one FIFO queue per requester plus the last winner.
  logic [DW-1:0] q [N][$];
  int            m_last;
  logic [N-1:0]  m_ovf;
  logic          exp_valid;
  logic [DW-1:0] exp_data;
  logic [IW-1:0] exp_vmid;

  vai_tx_rr_arb #(
    .NUM_SUB_AFUS(N), .DATA_W(DW), .SKID_DEPTH(DEPTH),
    .ALMFULL_SLACK(SLACK), .TAG_LSB(TLSB)
  ) dut (
    .Clk(Clk), .Resetb(Resetb), .in_valid(in_valid), .in_data(in_data),
    .in_almfull(in_almfull), .flush(flush), .out_almfull(out_almfull),
    .out_valid(out_valid), .out_data(out_data), .out_vmid(out_vmid),
    .err_overflow(err_overflow)
  );

  always #5 Clk = ~Clk;

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w = '0;
    for (int j = 0; j < DW; j += 32) w = (w << 32) | DW'($urandom());
    return w;
  endfunction

  function automatic logic [N-1:0] model_almfull();
    logic [N-1:0] a;
    for (int i = 0; i < N; i++) a[i] = (q[i].size() >= DEPTH - SLACK);
    return a;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) q[i].delete();
    m_last    = N - 1;
    m_ovf     = '0;
    exp_valid = 1'b0;
    exp_data  = '0;
    exp_vmid  = '0;
  endtask

  // Advance the model by one cycle using the currently driven inputs, then clock the DUT.
  task automatic tick();
    int g = -1;
    if (!out_almfull) begin
      for (int k = 1; k <= N; k++) begin
        int c = (m_last + k) % N;
        if (g < 0 && q[c].size() != 0 && !flush[c]) g = c;
      end
    end
    if (g >= 0) begin
      exp_valid = 1'b1;
      exp_data  = q[g][0];
`ifdef VAI_ARB_VMID_TAG_EN
      exp_data[TLSB +: IW] = IW'(g);
`endif
      exp_vmid  = IW'(g);
      m_last    = g;
      void'(q[g].pop_front());
    end else begin
      exp_valid = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (flush[i]) q[i].delete();
      else if (in_valid[i]) begin
        if (q[i].size() < DEPTH) q[i].push_back(in_data[i*DW +: DW]);
        else m_ovf[i] = 1'b1;
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic reset_dut();
    Resetb = 1'b0;
    in_valid = '0; flush = '0; out_almfull = 1'b0; in_data = '0;
    repeat (2) @(posedge Clk);
    #1;
    Resetb = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_vmid !== '0 ||
        err_overflow !== '0 || in_almfull !== '0) begin
      errors++;
      $display("FAIL reset_state got valid=%b vmid=%0d ovf=%h almf=%h exp all zero",
               out_valid, out_vmid, err_overflow, in_almfull);
    end
  endtask

  task automatic test_latency();
    reset_dut();
    repeat (3) tick();
    in_valid = 8'h08;
    in_data[3*DW +: DW] = DW'(16'hA5);
    tick();
    in_valid = '0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL latency_early got valid=%b exp 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== DW'(16'hA5) || out_vmid !== 3'd3) begin
      errors++;
      $display("FAIL latency_out got valid=%b data=%h vmid=%0d exp 1 a5 3", out_valid, out_data[15:0], out_vmid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL latency_single got valid=%b exp 0", out_valid);
    end
  endtask

  task automatic test_round_robin();
    reset_dut();
    out_almfull = 1'b1;
    in_valid = '1;
    repeat (2) begin
      for (int i = 0; i < N; i++) in_data[i*DW +: DW] = rand_word();
      tick();
    end
    in_valid = '0;
    checks++;
    if (in_almfull !== '1) begin
      errors++; $display("FAIL rr_almfull got %h exp ff", in_almfull);
    end
    out_almfull = 1'b0;
    tick();
    for (int k = 0; k < 2 * N; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_vmid !== IW'(k % N) || out_data !== exp_data) begin
        errors++;
        $display("FAIL rr_order slot %0d got valid=%b vmid=%0d exp 1 %0d", k, out_valid, out_vmid, k % N);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rr_drain got valid=%b exp 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    reset_dut();
    out_almfull = 1'b1;
    in_valid = 8'h04;
    for (int p = 0; p < DEPTH + 1; p++) begin
      in_data[2*DW +: DW] = DW'(p + 32'h10);
      tick();
      checks++;
      if (in_almfull[2] !== (p >= 1) || err_overflow[2] !== (p >= DEPTH)) begin
        errors++;
        $display("FAIL ovf_push %0d got almf=%b ovf=%b exp %b %b", p, in_almfull[2], err_overflow[2], p >= 1, p >= DEPTH);
      end
    end
    in_valid = '0;
    out_almfull = 1'b0;
    tick();
    for (int p = 0; p < DEPTH; p++) begin
      checks++;
      if (out_valid !== 1'b1 || out_vmid !== 3'd2 || out_data !== DW'(p + 32'h10)) begin
        errors++;
        $display("FAIL ovf_drain %0d got valid=%b vmid=%0d data=%h exp 1 2 %h", p, out_valid, out_vmid, out_data[15:0], p + 16);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || err_overflow !== 8'h04) begin
      errors++; $display("FAIL ovf_after got valid=%b ovf=%h exp 0 04", out_valid, err_overflow);
    end
  endtask

  task automatic test_flush();
    reset_dut();
    out_almfull = 1'b1;
    in_valid = 8'h22;
    repeat (2) begin
      in_data[1*DW +: DW] = rand_word();
      in_data[5*DW +: DW] = rand_word();
      tick();
    end
    in_valid = '0;
    out_almfull = 1'b0;
    flush = 8'h02;
    tick();
    flush = '0;
    checks++;
    if (out_valid !== 1'b1 || out_vmid !== 3'd5 || out_data !== exp_data) begin
      errors++; $display("FAIL flush_grant got valid=%b vmid=%0d exp 1 5", out_valid, out_vmid);
    end
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_almfull[1] !== 1'b0) begin
      errors++; $display("FAIL flush_empty got valid=%b vmid=%0d exp valid 0", out_valid, out_vmid);
    end
  endtask

  task automatic test_async_reset();
    reset_dut();
    out_almfull = 1'b1;
    in_valid = 8'h50;
    in_data[4*DW +: DW] = rand_word();
    in_data[6*DW +: DW] = rand_word();
    tick();
    in_valid = 8'h10;
    tick();
    in_valid = '0;
    out_almfull = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_vmid !== 3'd4) begin
      errors++; $display("FAIL areset_pre got valid=%b vmid=%0d exp 1 4", out_valid, out_vmid);
    end
    #2;
    Resetb = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_vmid !== '0) begin
      errors++; $display("FAIL areset_async got valid=%b vmid=%0d exp 0 0", out_valid, out_vmid);
    end
    repeat (2) @(posedge Clk);
    #1;
    Resetb = 1'b1;
    model_reset();
    repeat (2) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL areset_stale got valid=%b vmid=%0d exp 0", out_valid, out_vmid);
      end
    end
    in_valid = 8'h21;
    in_data[0*DW +: DW] = rand_word();
    in_data[5*DW +: DW] = rand_word();
    tick();
    in_valid = '0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_vmid !== 3'd0 || out_data !== exp_data) begin
      errors++; $display("FAIL areset_first got valid=%b vmid=%0d exp 1 0", out_valid, out_vmid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_vmid !== 3'd5) begin
      errors++; $display("FAIL areset_second got valid=%b vmid=%0d exp 1 5", out_valid, out_vmid);
    end
  endtask

  task automatic test_tag();
    logic [8:0] want;
`ifdef VAI_ARB_VMID_TAG_EN
    want = 9'h1F6;
`else
    want = 9'h1F0;
`endif
    reset_dut();
    in_valid = 8'h40;
    in_data[6*DW +: DW] = DW'(12'h1F0);
    tick();
    in_valid = '0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data[8:0] !== want || out_vmid !== 3'd6) begin
      errors++; $display("FAIL tag got valid=%b tag=%h vmid=%0d exp 1 %h 6", out_valid, out_data[8:0], out_vmid, want);
    end
  endtask

  task automatic test_random();
    reset_dut();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        in_valid[i] = ($urandom_range(0, 99) < 35);
        flush[i]    = ($urandom_range(0, 99) < 3);
        in_data[i*DW +: DW] = rand_word();
      end
      out_almfull = ($urandom_range(0, 99) < 25);
      tick();
      checks++;
      if (out_valid !== exp_valid || (exp_valid && (out_vmid !== exp_vmid || out_data !== exp_data)) ||
          err_overflow !== m_ovf || in_almfull !== model_almfull()) begin
        errors++;
        $display("FAIL rand cyc %0d got v=%b vmid=%0d ovf=%h almf=%h d=%h exp v=%b vmid=%0d ovf=%h almf=%h d=%h",
                 cyc, out_valid, out_vmid, err_overflow, in_almfull, out_data[63:0],
                 exp_valid, exp_vmid, m_ovf, model_almfull(), exp_data[63:0]);
      end
    end
    in_valid = '0;
    flush = '0;
    out_almfull = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_latency();
    test_round_robin();
    test_overflow();
    test_flush();
    test_async_reset();
    test_tag();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
